// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with ROM addressing, prefetch FIFO, redirects and fetch-fault capture
module fetch_ctrl #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter int          IM_DEPTH   = 4096,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_err,
    output logic [31:0] err_pc
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [32:0] PC_END = {1'b0, PC_RESET} + 33'(IM_DEPTH) * 33'd4;

    typedef enum logic {RUN, ERR} state_t;

    state_t         state_q, state_d;
    logic [31:0]    fpc_q, fpc_d;
    logic [31:0]    err_pc_q, err_pc_d;
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    pc_mem [FIFO_DEPTH];
    logic [31:0]    instr_mem [FIFO_DEPTH];
    logic           fpc_ok, deq, can_enq, push;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fpc_ok    = (fpc_q[1:0] == 2'b00) && (fpc_q >= PC_RESET) && ({1'b0, fpc_q} < PC_END);
    assign out_valid = (count_q != '0);
    assign deq       = out_valid && out_ready;
    assign can_enq   = (count_q < CW'(FIFO_DEPTH)) || deq;
    assign im_addr   = fpc_q;
    assign fetch_err = (state_q == ERR);
    assign err_pc    = err_pc_q;
    assign out_pc    = out_valid ? pc_mem[rd_q] : '0;
    assign out_instr = out_valid ? instr_mem[rd_q] : '0;

    // Next fetch PC, fault capture and push decision; a redirect discards any push this cycle
    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        err_pc_d = err_pc_q;
        push     = 1'b0;
        if (redirect_valid) begin
            state_d = RUN;
            fpc_d   = redirect_pc;
        end else if (state_q == RUN) begin
            if (!fpc_ok) begin
                state_d  = ERR;
                err_pc_d = fpc_q;
            end else if (can_enq) begin
                push  = 1'b1;
                fpc_d = fpc_q + 32'd4;
            end
        end
        wr_d    = redirect_valid ? '0 : (push ? inc(wr_q) : wr_q);
        rd_d    = redirect_valid ? '0 : (deq ? inc(rd_q) : rd_q);
        count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(deq);
    end

    // Control state and FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            fpc_q    <= PC_RESET;
            err_pc_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            err_pc_q <= err_pc_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
        end
    end

    // FIFO payload storage; contents are masked by count so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]    <= fpc_q;
            instr_mem[wr_q] <= im_instr;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch sequencing, stalls, redirects, faults and reset
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_err;
    logic [31:0] err_pc;
    int checks = 0;
    int failures = 0;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .im_addr(im_addr), .im_instr(im_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .fetch_err(fetch_err), .err_pc(err_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
    endfunction

    assign im_instr = rom(im_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        do_reset();
        checks++; if (im_addr !== 32'h3000) begin failures++; $display("FAIL reset_im_addr got=%h exp=%h", im_addr, 32'h3000); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_fetch_err got=%b exp=0", fetch_err); end
        checks++; if (err_pc !== 32'h0) begin failures++; $display("FAIL reset_err_pc got=%h exp=0", err_pc); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        out_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step();
            e = 32'h3000 + 32'(4 * (k - 1));
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_pc !== e) begin failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, out_pc, e); end
            checks++; if (out_instr !== rom(e)) begin failures++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, out_instr, rom(e)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        out_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        checks++; if (im_addr !== 32'h3008) begin failures++; $display("FAIL stall_im_addr got=%h exp=%h", im_addr, 32'h3008); end
        checks++; if (out_pc !== 32'h3000) begin failures++; $display("FAIL stall_head got=%h exp=%h", out_pc, 32'h3000); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = 32'h3000 + 32'(4 * i);
            checks++; if (out_pc !== e || out_valid !== 1'b1) begin failures++; $display("FAIL drain_pc i=%0d got=%h/%b exp=%h/1", i, out_pc, out_valid, e); end
            step();
        end
    endtask

    task automatic test_redirect_flush();
        out_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h3400;
        checks++; if (out_pc !== 32'h3000 || out_valid !== 1'b1) begin failures++; $display("FAIL flush_head got=%h/%b exp=%h/1", out_pc, out_valid, 32'h3000); end
        step();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b exp=0", out_valid); end
        checks++; if (im_addr !== 32'h3400) begin failures++; $display("FAIL flush_im_addr got=%h exp=%h", im_addr, 32'h3400); end
        step();
        checks++; if (out_pc !== 32'h3400 || out_valid !== 1'b1) begin failures++; $display("FAIL flush_target got=%h/%b exp=%h/1", out_pc, out_valid, 32'h3400); end
        checks++; if (out_instr !== rom(32'h3400)) begin failures++; $display("FAIL flush_instr got=%h exp=%h", out_instr, rom(32'h3400)); end
    endtask

    task automatic test_rom_end();
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h6FFC;
        step();
        redirect_valid = 1'b0;
        checks++; if (im_addr !== 32'h6FFC || out_valid !== 1'b0) begin failures++; $display("FAIL end_load got=%h/%b exp=%h/0", im_addr, out_valid, 32'h6FFC); end
        step();
        checks++; if (out_pc !== 32'h6FFC || im_addr !== 32'h7000 || fetch_err !== 1'b0) begin failures++; $display("FAIL end_last got=%h/%h/%b exp=6ffc/7000/0", out_pc, im_addr, fetch_err); end
        step();
        checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL end_err got=%b exp=1", fetch_err); end
        checks++; if (err_pc !== 32'h7000) begin failures++; $display("FAIL end_err_pc got=%h exp=%h", err_pc, 32'h7000); end
        checks++; if (out_pc !== 32'h6FFC || out_valid !== 1'b1) begin failures++; $display("FAIL end_hold got=%h/%b exp=6ffc/1", out_pc, out_valid); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || fetch_err !== 1'b1 || im_addr !== 32'h7000) begin failures++; $display("FAIL end_drain got=%b/%b/%h exp=0/1/7000", out_valid, fetch_err, im_addr); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL end_nopush got=%b exp=0", out_valid); end
    endtask

    task automatic test_misaligned();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h3002;
        step();
        redirect_valid = 1'b0;
        checks++; if (im_addr !== 32'h3002 || fetch_err !== 1'b0) begin failures++; $display("FAIL mis_load got=%h/%b exp=3002/0", im_addr, fetch_err); end
        step();
        checks++; if (fetch_err !== 1'b1 || err_pc !== 32'h3002) begin failures++; $display("FAIL mis_err got=%b/%h exp=1/3002", fetch_err, err_pc); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mis_nopush got=%b exp=0", out_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h3000;
        step();
        redirect_valid = 1'b0;
        checks++; if (fetch_err !== 1'b0 || im_addr !== 32'h3000 || err_pc !== 32'h3002) begin failures++; $display("FAIL mis_recover got=%b/%h/%h exp=0/3000/3002", fetch_err, im_addr, err_pc); end
        step();
        checks++; if (out_pc !== 32'h3000 || out_valid !== 1'b1) begin failures++; $display("FAIL mis_resume0 got=%h/%b exp=3000/1", out_pc, out_valid); end
        step();
        checks++; if (out_pc !== 32'h3004) begin failures++; $display("FAIL mis_resume1 got=%h exp=3004", out_pc); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h6FF8;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        step();
        checks++; if (fetch_err !== 1'b1 || out_valid !== 1'b1 || err_pc !== 32'h7000) begin failures++; $display("FAIL mid_setup got=%b/%b/%h exp=1/1/7000", fetch_err, out_valid, err_pc); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h3400;
        reset = 1'b1;
        step();
        reset = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || fetch_err !== 1'b0) begin failures++; $display("FAIL mid_flags got=%b/%b exp=0/0", out_valid, fetch_err); end
        checks++; if (err_pc !== 32'h0 || out_pc !== 32'h0) begin failures++; $display("FAIL mid_vals got=%h/%h exp=0/0", err_pc, out_pc); end
        checks++; if (im_addr !== 32'h3000) begin failures++; $display("FAIL mid_im_addr got=%h exp=%h", im_addr, 32'h3000); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_redirect_flush();
        test_rom_end();
        test_misaligned();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
